// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator: FSM state encoding,
// decimation-exponent clamp and the MSB-alignment shift.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } cic_state_t;

    // k = 0 would make R = 1 and let a dev collide with dev_d; never allow it.
    function automatic int clamp_k(input int sel, input int kmax);
        if (sel < 1) begin
            return 1;
        end
        if (sel > kmax) begin
            return kmax;
        end
        return sel;
    endfunction

    // Gain of the filter is R^ORDER = 2^(ORDER*k); shift it up to 2^(ORDER*kmax).
    function automatic int norm_shift(input int order, input int kmax, input int k);
        return order * (kmax - k);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One wrapping W-bit integrator stage of the CIC decimator.
module cic_integrator #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_decim.sv
// N-th order CIC decimator for a 1-bit modulator stream, runtime R = 2^k,
// single clock with sample qualifier and output strobe, MSB-aligned result.
//
//   state  | meaning
//   IDLE   | datapath cleared, k_act follows clamped dec_sel
//   SETTLE | filter running, first ORDER comb outputs not strobed
//   RUN    | out_valid pulses once per decimation event
module cic_decim
    import cic_pkg::*;
#(
    parameter int ORDER        = 3,
    parameter int DEC_LOG2_MAX = 8,
    parameter int OUT_W        = 14,
    localparam int W           = ORDER * DEC_LOG2_MAX + 1,
    localparam int KW          = $clog2(DEC_LOG2_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [KW-1:0]    dec_sel,
    input  logic             in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             settling
);

    localparam int SW = $clog2(ORDER + 1);

    cic_state_t              state;
    logic [KW-1:0]           k_act;
    logic [SW-1:0]           settle_cnt;
    logic [DEC_LOG2_MAX-1:0] cnt;
    logic [DEC_LOG2_MAX:0]   r_act;
    logic [DEC_LOG2_MAX-1:0] cnt_last;
    logic                    acc_en;
    logic                    dev;
    logic                    dev_d;
    logic                    clr_dp;
    logic [W-1:0]            acc [0:ORDER];
    logic [W-1:0]            z   [1:ORDER];
    logic [W-1:0]            c   [0:ORDER];
    logic [W-1:0]            norm;

    assign clr_dp   = (state == IDLE) || !enable;
    assign acc_en   = in_valid && (state != IDLE);
    assign r_act    = (DEC_LOG2_MAX + 1)'(1) << k_act;
    assign cnt_last = DEC_LOG2_MAX'(r_act - 1'b1);
    assign dev      = acc_en && (cnt == cnt_last);

    assign acc[0] = {{(W - 1){1'b0}}, in};

    // Each stage adds the pre-update value of the previous one.
    for (genvar i = 1; i <= ORDER; i++) begin : g_int
        cic_integrator #(.W(W)) u_int (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr_dp),
            .en      (acc_en),
            .din     (acc[i-1]),
            .acc     (acc[i])
        );
    end

    always_comb begin
        c[0] = acc[ORDER];
        for (int i = 1; i <= ORDER; i++) begin
            c[i] = c[i-1] - z[i];
        end
    end

    assign norm = c[ORDER] << norm_shift(ORDER, DEC_LOG2_MAX, int'(k_act));

    always_ff @(posedge clk) begin
        if (!reset_n || clr_dp) begin
            cnt   <= '0;
            dev_d <= 1'b0;
            for (int i = 1; i <= ORDER; i++) begin
                z[i] <= '0;
            end
        end else begin
            if (acc_en) begin
                cnt <= dev ? '0 : cnt + 1'b1;
            end
            dev_d <= dev;
            if (dev_d) begin
                for (int i = 1; i <= ORDER; i++) begin
                    z[i] <= c[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            settling   <= 1'b0;
            settle_cnt <= '0;
            k_act      <= KW'(clamp_k(int'(dec_sel), DEC_LOG2_MAX));
        end else begin
            case (state)
                IDLE: begin
                    k_act      <= KW'(clamp_k(int'(dec_sel), DEC_LOG2_MAX));
                    settle_cnt <= '0;
                    if (enable) begin
                        state    <= SETTLE;
                        settling <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        state      <= IDLE;
                        settling   <= 1'b0;
                        settle_cnt <= '0;
                    end else if (dev_d) begin
                        if (settle_cnt == SW'(ORDER - 1)) begin
                            state      <= RUN;
                            settling   <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    settling <= 1'b0;
                end
            endcase
        end
    end

    // out keeps its last value across a disable; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (dev_d && !clr_dp) begin
                out       <= OUT_W'(norm >> (W - OUT_W));
                out_valid <= (state == RUN);
            end
        end
    end

endmodule
